// File: rtl/mem_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, default
// geometry and the wait-state counter width.
// Imported by ram_ctrl and ram_array.
package mem_pkg;

    localparam int MEM_AW_DEF = 8;   // default address width
    localparam int MEM_DW_DEF = 8;   // default data width
    localparam int CNT_W      = 4;   // wait counter width, covers WAIT_CYC 0..15

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/ram_array.sv
// Byte array storage for the memory stage with a registered read port.
// Latency: write commits at the clock edge with we_i; read data appears one edge after re_i.
// Backpressure: none, one access per cycle, read data holds until the next read.
//
// Ports: clk_i/rst_n_i clock and async active-low reset (clears only the read
// register), addr_i/we_i/wdata_i/re_i access port, rdata_o registered read data,
// init_we_i/init_addr_i/init_data_i backdoor preload port (tie low when unused).
module ram_array
    import mem_pkg::*;
#(
    parameter int AW = MEM_AW_DEF,
    parameter int DW = MEM_DW_DEF
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    output logic [DW-1:0] rdata_o,
    input  logic          init_we_i,
    input  logic [AW-1:0] init_addr_i,
    input  logic [DW-1:0] init_data_i
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    // Storage has no reset: contents survive a controller reset.
    // The preload port wins over a functional write in the same cycle.
    always_ff @(posedge clk_i) begin
        if (init_we_i) begin
            mem_q[init_addr_i] <= init_data_i;
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// Memory stage ahead of the MBR: latches a request, waits WAIT_CYC cycles, accesses the array, pulses MFC.
// Latency: MFC is high in cycle WAIT_CYC+2 after the sampling edge; next request at WAIT_CYC+3 at the earliest.
// Backpressure: requests are sampled only in IDLE; enable is ignored while busy is high.
//
// Ports: CLK clock, reset_n async active-low reset, enable request strobe (WMFC),
// rnw 1=read/0=write, mar address, wdata write data, rdata read data to MBR,
// MFC one-cycle completion pulse, busy high outside IDLE.
module ram_ctrl
    import mem_pkg::*;
#(
    parameter int          AW       = MEM_AW_DEF,
    parameter int          DW       = MEM_DW_DEF,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          enable,
    input  logic          rnw,
    input  logic [AW-1:0] mar,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          MFC,
    output logic          busy
);

    logic [1:0]    state_q, state_d;
    cnt_t          cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rnw_q, rnw_d;
    logic [DW-1:0] wdat_q, wdat_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        wdat_d  = wdat_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    addr_d  = mar;
                    rnw_d   = rnw;
                    wdat_d  = wdata;
                    cnt_d   = cnt_t'(WAIT_CYC);
                    state_d = (WAIT_CYC == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                // Leaving on count 1 makes WAIT last exactly WAIT_CYC cycles.
                cnt_d = cnt_q - cnt_t'(1);
                if (cnt_q == cnt_t'(1)) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_DONE;
            default:  state_d = S_IDLE;   // S_DONE: control unit advances here
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rnw_q   <= 1'b0;
            wdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            wdat_q  <= wdat_d;
        end
    end

    // The array acts on the closing edge of ACCESS; an async reset before
    // that edge leaves state_q out of ACCESS so nothing is committed.
    logic in_access;
    assign in_access = (state_q == S_ACCESS);

    ram_array #(
        .AW (AW),
        .DW (DW)
    ) u_array (
        .clk_i       (CLK),
        .rst_n_i     (reset_n),
        .addr_i      (addr_q),
        .we_i        (in_access && !rnw_q),
        .wdata_i     (wdat_q),
        .re_i        (in_access && rnw_q),
        .rdata_o     (rdata),
        .init_we_i   (1'b0),
        .init_addr_i ('0),
        .init_data_i ('0)
    );

    // Decoded straight from the state register, so both drop with reset.
    assign MFC  = (state_q == S_DONE);
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_ctrl.sv
module tb_ram_ctrl;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       en2, en0;
    logic       rnw;
    logic [7:0] mar, wdata;
    logic [7:0] rdata2, rdata0;
    logic       mfc2, mfc0, busy2, busy0;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    ram_ctrl #(.AW(8), .DW(8), .WAIT_CYC(2)) u_dut2 (
        .CLK(CLK), .reset_n(reset_n), .enable(en2), .rnw(rnw), .mar(mar),
        .wdata(wdata), .rdata(rdata2), .MFC(mfc2), .busy(busy2)
    );

    ram_ctrl #(.AW(8), .DW(8), .WAIT_CYC(0)) u_dut0 (
        .CLK(CLK), .reset_n(reset_n), .enable(en0), .rnw(rnw), .mar(mar),
        .wdata(wdata), .rdata(rdata0), .MFC(mfc0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Issue one request on the selected DUT, check the MFC cycle number and
    // return rdata sampled in the DONE cycle. scramble changes the request
    // inputs during cycle 1 to show they are ignored once latched.
    task automatic req(input bit sel0, input logic r, input logic [7:0] a,
                       input logic [7:0] d, input int exp_lat, input bit scramble,
                       input string tag, output logic [7:0] rd);
        int k;
        rnw = r; mar = a; wdata = d;
        if (sel0) en0 = 1'b1; else en2 = 1'b1;
        step();                                  // edge 0, now in cycle 1
        en0 = 1'b0; en2 = 1'b0;
        if (scramble) begin
            mar = a + 8'd1; rnw = 1'b0; wdata = 8'hEE;
        end
        for (k = 1; k <= 20; k++) begin
            if ((sel0 ? mfc0 : mfc2) === 1'b1) break;
            step();
        end
        check({tag, "_mfc_cycle"}, k, exp_lat);
        rd = sel0 ? rdata0 : rdata2;
        step();                                  // leave DONE
    endtask

    logic [7:0] rd;
    int         pulses;

    initial begin
        reset_n = 1'b0; en2 = 1'b0; en0 = 1'b0; rnw = 1'b0; mar = '0; wdata = '0;
        #3;
        check("rst_rdata", rdata2, 8'h00);
        check("rst_mfc",   mfc2,   1'b0);
        check("rst_busy",  busy2,  1'b0);
        @(negedge CLK);
        reset_n = 1'b1;
        step();

        // Write 0x10 <= 0xA5 with cycle-by-cycle busy/MFC view, WAIT_CYC = 2
        rnw = 1'b0; mar = 8'h10; wdata = 8'hA5; en2 = 1'b1;
        step();
        en2 = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check($sformatf("wr_busy_c%0d", c), busy2, 1'b1);
            check($sformatf("wr_mfc_c%0d", c), mfc2, (c == 4));
            step();
        end
        check("wr_busy_c5", busy2, 1'b0);
        check("wr_rdata_held", rdata2, 8'h00);
        req(1'b0, 1'b1, 8'h10, 8'h00, 4, 1'b0, "rd10", rd);
        check("rd10_data", rd, 8'hA5);

        // WAIT_CYC = 0: MFC in cycle 2
        req(1'b1, 1'b0, 8'h3F, 8'h5C, 2, 1'b0, "wr3f", rd);
        req(1'b1, 1'b1, 8'h3F, 8'h00, 2, 1'b0, "rd3f", rd);
        check("rd3f_data", rd, 8'h5C);

        // Inputs changed during WAIT are ignored
        req(1'b0, 1'b0, 8'h20, 8'h11, 4, 1'b0, "wr20", rd);
        req(1'b0, 1'b0, 8'h21, 8'h22, 4, 1'b0, "wr21", rd);
        req(1'b0, 1'b1, 8'h20, 8'h00, 4, 1'b1, "rd20s", rd);
        check("rd20s_data", rd, 8'h11);
        req(1'b0, 1'b1, 8'h21, 8'h00, 4, 1'b0, "rd21", rd);
        check("rd21_data", rd, 8'h22);

        // enable held high over two passes: requests at edges 0 and 5 only
        req(1'b0, 1'b0, 8'h41, 8'h77, 4, 1'b0, "wr41", rd);
        for (int i = 0; i < 12; i++) begin
            en2 = (i < 10); rnw = 1'b0; mar = 8'h40 + 8'(i); wdata = 8'h80 + 8'(i);
            step();                              // now in cycle i+1
            check($sformatf("hold_mfc_c%0d", i + 1), mfc2, ((i + 1) == 4) || ((i + 1) == 9));
        end
        en2 = 1'b0;
        check("hold_rdata", rdata2, 8'h22);
        step(); step();
        req(1'b0, 1'b1, 8'h40, 8'h00, 4, 1'b0, "rd40", rd);
        check("rd40_data", rd, 8'h80);
        req(1'b0, 1'b1, 8'h45, 8'h00, 4, 1'b0, "rd45", rd);
        check("rd45_data", rd, 8'h85);
        req(1'b0, 1'b1, 8'h41, 8'h00, 4, 1'b0, "rd41", rd);
        check("rd41_data", rd, 8'h77);

        // Reset during WAIT aborts the write
        req(1'b0, 1'b0, 8'h05, 8'h00, 4, 1'b0, "wr05", rd);
        rnw = 1'b0; mar = 8'h05; wdata = 8'hFF; en2 = 1'b1;
        step();                                  // cycle 1, WAIT
        en2 = 1'b0;
        check("abort_busy_pre", busy2, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_mfc",   mfc2,   1'b0);
        check("abort_busy",  busy2,  1'b0);
        check("abort_rdata", rdata2, 8'h00);
        check("abort_rdata0", rdata0, 8'h00);
        @(negedge CLK);
        reset_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (mfc2 === 1'b1) pulses++;
        end
        check("abort_no_mfc", pulses, 0);
        req(1'b0, 1'b1, 8'h05, 8'h00, 4, 1'b0, "rd05", rd);
        check("rd05_data", rd, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
